// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared constants for the accumulator-CPU sequencer.
//   Opcode values (instruction bits [7:5]), phase names of the 8-phase
//   fetch/execute cycle, and is_aluop() which flags the opcodes whose result
//   comes back through the alu into the accumulator.
package ctrl_pkg;

   localparam int CTRL_OPCODE_W = 3;
   localparam int CTRL_PHASE_W  = 3;

   localparam logic [2:0] OP_HLT = 3'd0;
   localparam logic [2:0] OP_SKZ = 3'd1;
   localparam logic [2:0] OP_ADD = 3'd2;
   localparam logic [2:0] OP_AND = 3'd3;
   localparam logic [2:0] OP_XOR = 3'd4;
   localparam logic [2:0] OP_LDA = 3'd5;
   localparam logic [2:0] OP_STO = 3'd6;
   localparam logic [2:0] OP_JMP = 3'd7;

   localparam logic [2:0] PH_INST_ADDR  = 3'd0;
   localparam logic [2:0] PH_INST_FETCH = 3'd1;
   localparam logic [2:0] PH_INST_LOAD  = 3'd2;
   localparam logic [2:0] PH_IDLE       = 3'd3;
   localparam logic [2:0] PH_OP_ADDR    = 3'd4;
   localparam logic [2:0] PH_OP_FETCH   = 3'd5;
   localparam logic [2:0] PH_ALU_OP     = 3'd6;
   localparam logic [2:0] PH_STORE      = 3'd7;

   function automatic logic is_aluop(input logic [2:0] op);
      return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
   endfunction

endpackage

// File: rtl/ctrl_sequencer_phase_counter.sv
// phase_counter: free-running phase counter for the sequencer.
//   Ports:
//     i_clk     clock, all updates on posedge
//     i_rst     synchronous active-high reset (to phase 0), beats everything
//     i_en      advance enable
//     i_freeze  hold request (halt / single-step park), overrides i_en
//     o_phase   current phase, wraps at 2**PHASE_W
module phase_counter
   import ctrl_pkg::*;
#(
   parameter int PHASE_W = CTRL_PHASE_W
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_en,
   input  logic               i_freeze,
   output logic [PHASE_W-1:0] o_phase
);

   logic [PHASE_W-1:0] r_phase;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_phase <= '0;
      end else if (i_en && !i_freeze) begin
         r_phase <= r_phase + PHASE_W'(1);
      end
   end

   assign o_phase = r_phase;

endmodule

// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer: instruction sequencer/decoder for the 8-bit accumulator CPU.
//   Steps an 8-phase fetch/execute cycle, latches the opcode for the alu and
//   decodes all datapath strobes combinationally from (phase, opcode, zero_q).
//
//   phase | meaning
//   ------+----------------------------------------------
//     0   | PH_INST_ADDR  : PC onto address bus
//     1   | PH_INST_FETCH : read instruction
//     2   | PH_INST_LOAD  : load IR
//     3   | PH_IDLE       : IR settles, opcode captured on exit
//     4   | PH_OP_ADDR    : inc PC; HLT sets halt on exit
//     5   | PH_OP_FETCH   : operand read; a_is_zero captured on exit
//     6   | PH_ALU_OP     : alu op / SKZ skip / JMP / STO drive
//     7   | PH_STORE      : accumulator load / JMP / STO write
//
//   Ports: clk, rst (sync, active-high), en (advance enable), ir_opcode,
//   a_is_zero, [step]; outputs opcode, phase, sel, rd, ld_ir, inc_pc, ld_pc,
//   ld_ac, wr, data_e, halt (sticky until rst).
//
//   Build option CTRL_SINGLE_STEP_EN: adds input step; the 0->1 advance also
//   requires step=1, so each step pulse runs one complete instruction.
module ctrl_sequencer
   import ctrl_pkg::*;
#(
   parameter int OPCODE_W = CTRL_OPCODE_W,
   parameter int PHASE_W  = CTRL_PHASE_W
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic [OPCODE_W-1:0] ir_opcode,
   input  logic                a_is_zero,
`ifdef CTRL_SINGLE_STEP_EN
   input  logic                step,
`endif
   output logic [OPCODE_W-1:0] opcode,
   output logic [PHASE_W-1:0]  phase,
   output logic                sel,
   output logic                rd,
   output logic                ld_ir,
   output logic                inc_pc,
   output logic                ld_pc,
   output logic                ld_ac,
   output logic                wr,
   output logic                data_e,
   output logic                halt
);

   logic [OPCODE_W-1:0] r_opcode;
   logic                r_zero_q;
   logic                r_halt;
   logic [PHASE_W-1:0]  w_phase;
   logic                w_step_park;
   logic                w_hold;
   logic                w_adv;
   logic                w_aluop;

`ifdef CTRL_SINGLE_STEP_EN
   assign w_step_park = (w_phase == PH_INST_ADDR) && !step;
`else
   assign w_step_park = 1'b0;
`endif

   assign w_hold = r_halt || w_step_park;
   // Latches move only on an actual phase advance, so en=0 freezes them too.
   assign w_adv  = en && !w_hold;

   phase_counter #(.PHASE_W(PHASE_W)) u_phase_counter (
      .i_clk    (clk),
      .i_rst    (rst),
      .i_en     (en),
      .i_freeze (w_hold),
      .o_phase  (w_phase)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_opcode <= '0;
         r_zero_q <= 1'b0;
         r_halt   <= 1'b0;
      end else if (w_adv) begin
         if (w_phase == PH_IDLE)     r_opcode <= ir_opcode;
         if (w_phase == PH_OP_FETCH) r_zero_q <= a_is_zero;
         if (w_phase == PH_OP_ADDR && r_opcode == OP_HLT) r_halt <= 1'b1;
      end
   end

   assign w_aluop = is_aluop(r_opcode);

   always_comb begin
      sel    = 1'b0;
      rd     = 1'b0;
      ld_ir  = 1'b0;
      inc_pc = 1'b0;
      ld_pc  = 1'b0;
      ld_ac  = 1'b0;
      wr     = 1'b0;
      data_e = 1'b0;
      case (w_phase)
         PH_INST_ADDR:  sel = 1'b1;
         PH_INST_FETCH: begin
            sel = 1'b1;
            rd  = 1'b1;
         end
         PH_INST_LOAD, PH_IDLE: begin
            sel   = 1'b1;
            rd    = 1'b1;
            ld_ir = 1'b1;
         end
         PH_OP_ADDR:    inc_pc = 1'b1;
         PH_OP_FETCH:   rd = w_aluop;
         PH_ALU_OP: begin
            rd     = w_aluop;
            inc_pc = (r_opcode == OP_SKZ) && r_zero_q;
            ld_pc  = (r_opcode == OP_JMP);
            data_e = (r_opcode == OP_STO);
         end
         PH_STORE: begin
            rd     = w_aluop;
            ld_ac  = w_aluop;
            ld_pc  = (r_opcode == OP_JMP);
            wr     = (r_opcode == OP_STO);
            data_e = (r_opcode == OP_STO);
         end
         default: ;
      endcase
      // A halted CPU drives no strobes at all.
      if (r_halt) begin
         sel    = 1'b0;
         rd     = 1'b0;
         ld_ir  = 1'b0;
         inc_pc = 1'b0;
         ld_pc  = 1'b0;
         ld_ac  = 1'b0;
         wr     = 1'b0;
         data_e = 1'b0;
      end
   end

   assign opcode = r_opcode;
   assign phase  = w_phase;
   assign halt   = r_halt;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Self-checking bench for ctrl_sequencer: a directed vector table, hand-written
// multi-cycle corner cases and a randomized run against a behavioural model.
module tb_ctrl_sequencer;

   logic       clk = 1'b0;
   logic       rst, en, a_is_zero, step;
   logic [2:0] ir_opcode;
   logic [2:0] opcode, phase;
   logic       sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt;

   int n_checks = 0;
   int n_errors = 0;

   // behavioural model state
   int m_ph = 0, m_op = 0;
   bit m_zq = 0, m_h = 0;

   always #5 clk = ~clk;

   ctrl_sequencer dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .ir_opcode (ir_opcode),
      .a_is_zero (a_is_zero),
`ifdef CTRL_SINGLE_STEP_EN
      .step      (step),
`endif
      .opcode    (opcode),
      .phase     (phase),
      .sel       (sel),
      .rd        (rd),
      .ld_ir     (ld_ir),
      .inc_pc    (inc_pc),
      .ld_pc     (ld_pc),
      .ld_ac     (ld_ac),
      .wr        (wr),
      .data_e    (data_e),
      .halt      (halt)
   );

   typedef struct {
      bit         rst;
      bit         en;
      logic [2:0] ir;
      bit         az;
      logic [2:0] ph;
      logic [2:0] op;
      logic [7:0] stb;   // sel rd ld_ir inc_pc ld_pc ld_ac wr data_e
      bit         hlt;
   } vec_t;

   vec_t tbl[19];

   function automatic logic [7:0] dut_stb();
      return {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e};
   endfunction

   function automatic logic [14:0] dut_all();
      return {opcode, phase, dut_stb(), halt};
   endfunction

   // Strobe rules written as phase ranges per opcode class.
   function automatic logic [7:0] model_stb(int ph, int op, bit zq, bit h);
      bit alu;
      bit s_sel, s_rd, s_ldir, s_inc, s_ldpc, s_ldac, s_wr, s_de;
      alu    = (op >= 2 && op <= 5);
      s_sel  = (ph <= 3);
      s_rd   = (ph >= 1 && ph <= 3) || (ph >= 5 && alu);
      s_ldir = (ph == 2 || ph == 3);
      s_inc  = (ph == 4) || (ph == 6 && op == 1 && zq);
      s_ldpc = (ph >= 6 && op == 7);
      s_ldac = (ph == 7 && alu);
      s_wr   = (ph == 7 && op == 6);
      s_de   = (ph >= 6 && op == 6);
      if (h) return 8'h00;
      return {s_sel, s_rd, s_ldir, s_inc, s_ldpc, s_ldac, s_wr, s_de};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic run(input bit r, input bit e, input logic [2:0] ir, input bit az, input bit st);
      logic [14:0] exp;
      bit          adv;
      rst = r; en = e; ir_opcode = ir; a_is_zero = az; step = st;
      @(posedge clk);
      #1;
      if (r) begin
         m_ph = 0; m_op = 0; m_zq = 0; m_h = 0;
      end else begin
         adv = e && !m_h;
`ifdef CTRL_SINGLE_STEP_EN
         if (m_ph == 0 && !st) adv = 0;
`endif
         if (adv) begin
            if (m_ph == 3) m_op = int'(ir);
            if (m_ph == 5) m_zq = az;
            if (m_ph == 4 && m_op == 0) m_h = 1;
            m_ph = (m_ph + 1) % 8;
         end
      end
      exp = {3'(m_op), 3'(m_ph), model_stb(m_ph, m_op, m_zq, m_h), m_h};
      chk("model", 32'(dut_all()), 32'(exp));
      chk("wr_de_window", 32'((wr || data_e) && !(phase == 3'd6 || phase == 3'd7)), 32'd0);
      chk("inc_ldpc_excl", 32'(inc_pc && ld_pc), 32'd0);
   endtask

   // Advance with en=1 until the model reaches phase p (bounded).
   task automatic goto_ph(input int p, input logic [2:0] ir, input bit az);
      int n = 0;
      while (m_ph != p && n < 16) begin
         run(0, 1, ir, az, 1);
         n++;
      end
      chk("goto_bound", 32'(m_ph), 32'(p));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1; en = 1; ir_opcode = 0; a_is_zero = 0; step = 1;

      // reset, ADD instruction, STO instruction, en=0 hold in ph0
      tbl[0]  = '{1,1,3'd2,0, 3'd0,3'd0,8'b1000_0000,0};
      tbl[1]  = '{1,1,3'd2,0, 3'd0,3'd0,8'b1000_0000,0};
      tbl[2]  = '{0,1,3'd2,0, 3'd1,3'd0,8'b1100_0000,0};
      tbl[3]  = '{0,1,3'd2,0, 3'd2,3'd0,8'b1110_0000,0};
      tbl[4]  = '{0,1,3'd2,0, 3'd3,3'd0,8'b1110_0000,0};
      tbl[5]  = '{0,1,3'd2,0, 3'd4,3'd2,8'b0001_0000,0};
      tbl[6]  = '{0,1,3'd2,0, 3'd5,3'd2,8'b0100_0000,0};
      tbl[7]  = '{0,1,3'd2,1, 3'd6,3'd2,8'b0100_0000,0};
      tbl[8]  = '{0,1,3'd2,0, 3'd7,3'd2,8'b0100_0100,0};
      tbl[9]  = '{0,1,3'd2,0, 3'd0,3'd2,8'b1000_0000,0};
      tbl[10] = '{0,1,3'd6,0, 3'd1,3'd2,8'b1100_0000,0};
      tbl[11] = '{0,1,3'd6,0, 3'd2,3'd2,8'b1110_0000,0};
      tbl[12] = '{0,1,3'd6,0, 3'd3,3'd2,8'b1110_0000,0};
      tbl[13] = '{0,1,3'd6,0, 3'd4,3'd6,8'b0001_0000,0};
      tbl[14] = '{0,1,3'd6,0, 3'd5,3'd6,8'b0000_0000,0};
      tbl[15] = '{0,1,3'd6,0, 3'd6,3'd6,8'b0000_0001,0};
      tbl[16] = '{0,1,3'd6,0, 3'd7,3'd6,8'b0000_0011,0};
      tbl[17] = '{0,1,3'd6,0, 3'd0,3'd6,8'b1000_0000,0};
      tbl[18] = '{0,0,3'd6,0, 3'd0,3'd6,8'b1000_0000,0};

      for (int i = 0; i < 19; i++) begin
         run(tbl[i].rst, tbl[i].en, tbl[i].ir, tbl[i].az, 1);
         chk($sformatf("vec%0d", i), 32'(dut_all()),
             32'({tbl[i].op, tbl[i].ph, tbl[i].stb, tbl[i].hlt}));
      end

      // SKZ with zero flag set: skip strobe in ph4 and ph6
      run(1, 1, 3'd1, 1, 1);
      goto_ph(4, 3'd1, 1);
      chk("skz_z_inc_ph4", 32'(inc_pc), 32'd1);
      goto_ph(6, 3'd1, 1);
      chk("skz_z_inc_ph6", 32'(inc_pc), 32'd1);
      // SKZ with zero flag clear: no skip in ph6
      goto_ph(0, 3'd1, 0);
      goto_ph(6, 3'd1, 0);
      chk("skz_nz_inc_ph6", 32'(inc_pc), 32'd0);

      // JMP, with en=0 held in ph6 for 5 clocks
      goto_ph(0, 3'd7, 0);
      goto_ph(6, 3'd7, 0);
      chk("jmp_ldpc_ph6", 32'({ld_pc, inc_pc}), 32'b10);
      for (int i = 0; i < 5; i++) begin
         run(0, 0, 3'd7, 0, 1);
         chk("hold_ph6", 32'({phase, ld_pc}), 32'({3'd6, 1'b1}));
      end
      run(0, 1, 3'd7, 0, 1);
      chk("jmp_ldpc_ph7", 32'({phase, ld_pc, inc_pc}), 32'({3'd7, 2'b10}));

      // rst in ph7 of STO: wr drops on the next cycle
      goto_ph(0, 3'd6, 0);
      goto_ph(7, 3'd6, 0);
      chk("sto_wr_ph7", 32'({wr, data_e}), 32'b11);
      run(1, 1, 3'd6, 0, 1);
      chk("sto_rst_wr", 32'({phase, wr, data_e}), 32'({3'd0, 2'b00}));

      // HLT: sticky halt at ph5, everything frozen until rst
      run(0, 1, 3'd0, 0, 1);
      goto_ph(5, 3'd0, 0);
      chk("hlt_set", 32'({phase, halt}), 32'({3'd5, 1'b1}));
      for (int i = 0; i < 20; i++) begin
         run(0, 1, 3'($urandom_range(0, 7)), 1'($urandom), 1);
         chk("hlt_frozen", 32'({phase, dut_stb(), halt}), 32'({3'd5, 8'h00, 1'b1}));
      end
      run(1, 1, 3'd2, 0, 1);
      chk("hlt_rst", 32'({phase, halt, sel}), 32'({3'd0, 1'b0, 1'b1}));

`ifdef CTRL_SINGLE_STEP_EN
      for (int i = 0; i < 4; i++) begin
         run(0, 1, 3'd2, 0, 0);
         chk("step_park", 32'(phase), 32'd0);
      end
      run(0, 1, 3'd2, 0, 1);
      chk("step_go", 32'(phase), 32'd1);
      for (int i = 0; i < 9; i++) run(0, 1, 3'd2, 0, 0);
      chk("step_one_instr", 32'(phase), 32'd0);
`endif

      // randomized run against the model
      for (int i = 0; i < 3000; i++) begin
         run(($urandom_range(0, 39) == 0), ($urandom_range(0, 9) != 0),
             3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
